// File: rtl/moving_avg_param_pkg.sv
// rtl/moving_avg_param_pkg.sv - shared constants for the moving-average filter
package moving_avg_param_pkg;

    localparam int DEF_WIDTH      = 10;
    localparam int DEF_LOG2_DEPTH = 4;

    localparam int ROUND_FLOOR    = 0;
    localparam int ROUND_HALF_UP  = 1;

endpackage

// File: rtl/mavg_ring_buf.sv
// rtl/mavg_ring_buf.sv - sample storage: one synchronous write port, one combinational read port
module mavg_ring_buf #(
    parameter int WIDTH = 10,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] r_mem [2**AW];

    // Contents are deliberately never cleared; the count gating upstream keeps stale entries out.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/moving_avg_param.sv
// rtl/moving_avg_param.sv - streaming mean of the last 2**win_sel samples via a running sum
module moving_avg_param
    import moving_avg_param_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int LOG2_DEPTH = DEF_LOG2_DEPTH,
    parameter int ROUND      = ROUND_FLOOR,
    parameter int WSEL_W     = $clog2(LOG2_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              e_in,
    input  logic [WIDTH-1:0]  data_in,
    input  logic [WSEL_W-1:0] win_sel,
    output logic [WIDTH-1:0]  data_out,
    output logic              e_out,
    output logic              filled
);

    localparam int SW = WIDTH + LOG2_DEPTH;
    localparam int CW = LOG2_DEPTH + 1;

    logic [LOG2_DEPTH-1:0] r_wr_ptr;
    logic [CW-1:0]         r_count;
    logic [SW-1:0]         r_sum;
    logic [WSEL_W-1:0]     r_win_q;
    logic [WIDTH-1:0]      r_data_out;
    logic                  r_e_out;
    logic                  r_filled;

    logic [WSEL_W-1:0]     w_k;
    logic [CW-1:0]         w_n;
    logic                  w_restart;
    logic [LOG2_DEPTH-1:0] w_ptr;
    logic [CW-1:0]         w_cnt;
    logic [SW-1:0]         w_sum;
    logic [LOG2_DEPTH-1:0] w_raddr;
    logic [WIDTH-1:0]      w_rdata;
    logic [WIDTH-1:0]      w_old;
    logic [SW-1:0]         w_sum_next;
    logic [CW-1:0]         w_cnt_next;
    logic [SW:0]           w_rnd;
    logic [WIDTH-1:0]      w_avg;
    logic                  w_we;

    always_comb begin
        w_k = win_sel;
        if (win_sel > WSEL_W'(LOG2_DEPTH)) begin
            w_k = WSEL_W'(LOG2_DEPTH);
        end
    end

    assign w_n       = CW'(1) << w_k;
    assign w_restart = (w_k != r_win_q);

    // A window change restarts the accumulation; an accept on the same edge starts the new window.
    assign w_ptr = w_restart ? '0 : r_wr_ptr;
    assign w_cnt = w_restart ? '0 : r_count;
    assign w_sum = w_restart ? '0 : r_sum;

    // N == DEPTH truncates to 0 here, which correctly addresses the slot about to be overwritten.
    assign w_raddr = r_wr_ptr - w_n[LOG2_DEPTH-1:0];
    assign w_old   = (w_cnt == w_n) ? w_rdata : '0;

    assign w_sum_next = w_sum + SW'(data_in) - SW'(w_old);
    assign w_cnt_next = (w_cnt == w_n) ? w_n : w_cnt + CW'(1);

    // (1 << k) >> 1 yields 2**(k-1) for k > 0 and 0 for k == 0.
    assign w_rnd = (ROUND == ROUND_HALF_UP) ? ((SW'(1) << w_k) >> 1) : '0;
    assign w_avg = WIDTH'(({1'b0, w_sum_next} + w_rnd) >> w_k);

    assign w_we = e_in && !RST;

    mavg_ring_buf #(
        .WIDTH (WIDTH),
        .AW    (LOG2_DEPTH)
    ) u_ring_buf (
        .clk   (clk),
        .we    (w_we),
        .waddr (w_ptr),
        .wdata (data_in),
        .raddr (w_raddr),
        .rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (RST) begin
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_sum      <= '0;
            r_win_q    <= '0;
            r_data_out <= '0;
            r_e_out    <= 1'b0;
            r_filled   <= 1'b0;
        end else begin
            r_e_out <= 1'b0;
            if (w_restart) begin
                r_win_q  <= w_k;
                r_wr_ptr <= '0;
                r_count  <= '0;
                r_sum    <= '0;
                r_filled <= 1'b0;
            end
            if (e_in) begin
                r_wr_ptr   <= w_ptr + LOG2_DEPTH'(1);
                r_count    <= w_cnt_next;
                r_sum      <= w_sum_next;
                r_filled   <= (w_cnt_next == w_n);
                r_data_out <= w_avg;
                r_e_out    <= 1'b1;
            end
        end
    end

    assign data_out = r_data_out;
    assign e_out    = r_e_out;
    assign filled   = r_filled;

endmodule

// File: tb/tb_moving_avg_param.sv
// tb/tb_moving_avg_param.sv - self-checking bench for moving_avg_param (floor and round-half-up instances)
module tb_moving_avg_param;

    logic       clk = 1'b0;
    logic       RST = 1'b1;
    logic       e_in = 1'b0;
    logic [9:0] data_in = '0;
    logic [2:0] win_sel = '0;

    logic [9:0] out0, out1;
    logic       e0, e1, f0, f1;

    int n_checks = 0;
    int n_errors = 0;
    bit checking = 1'b0;

    always #5 clk = ~clk;

    moving_avg_param #(.WIDTH(10), .LOG2_DEPTH(4), .ROUND(0)) dut0 (
        .clk(clk), .RST(RST), .e_in(e_in), .data_in(data_in), .win_sel(win_sel),
        .data_out(out0), .e_out(e0), .filled(f0)
    );

    moving_avg_param #(.WIDTH(10), .LOG2_DEPTH(4), .ROUND(1)) dut1 (
        .clk(clk), .RST(RST), .e_in(e_in), .data_in(data_in), .win_sel(win_sel),
        .data_out(out1), .e_out(e1), .filled(f1)
    );

    // Model: keep the samples seen since the last restart and average the newest N of them.
    int  hist[$];
    int  m_k = 0;
    int  m_out0 = 0;
    int  m_out1 = 0;
    bit  m_e = 1'b0;
    bit  m_filled = 1'b0;

    always @(posedge clk) begin
        int kc;
        int n;
        int s;
        kc = (win_sel > 3'd4) ? 4 : int'(win_sel);
        if (RST) begin
            hist.delete();
            m_k = 0; m_out0 = 0; m_out1 = 0; m_e = 0; m_filled = 0;
        end else begin
            m_e = 0;
            if (kc != m_k) begin
                hist.delete();
                m_k = kc;
                m_filled = 0;
            end
            if (e_in) begin
                hist.push_back(int'(data_in));
                if (hist.size() > 16) void'(hist.pop_front());
                n = 1 << m_k;
                s = 0;
                for (int i = 0; i < n && i < hist.size(); i++) s += hist[hist.size() - 1 - i];
                m_out0 = s / n;
                m_out1 = (s + n / 2) / n;
                m_filled = (hist.size() >= n);
                m_e = 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            chk("model out0", 32'(out0), m_out0);
            chk("model out1", 32'(out1), m_out1);
            chk("model e0", 32'(e0), 32'(m_e));
            chk("model e1", 32'(e1), 32'(m_e));
            chk("model f0", 32'(f0), 32'(m_filled));
            chk("model f1", 32'(f1), 32'(m_filled));
        end
    end

    task automatic step(input logic rst, input logic e, input int d, input int ws);
        RST = rst;
        e_in = e;
        data_in = d[9:0];
        win_sel = ws[2:0];
        @(posedge clk);
        @(negedge clk);
    endtask

    int s1[5] = '{80, 60, 75, 68, 55};
    int x0[5] = '{20, 35, 53, 70, 64};
    int x1[5] = '{20, 35, 54, 71, 65};

    initial begin
        @(negedge clk);
        step(1, 0, 0, 2);
        step(1, 1, 77, 2);
        chk("reset data_out", 32'(out0), 0);
        chk("reset e_out", 32'(e0), 0);
        chk("reset filled", 32'(f0), 0);
        checking = 1'b1;

        for (int i = 0; i < 5; i++) begin
            step(0, 1, s1[i], 2);
            chk("t1 floor out", 32'(out0), x0[i]);
            chk("t2 round out", 32'(out1), x1[i]);
            chk("t1 e_out", 32'(e0), 1);
            if (i == 2) chk("t1 filled before 4th", 32'(f0), 0);
            if (i == 3) chk("t1 filled at 4th", 32'(f0), 1);
        end
        step(0, 0, 0, 2);
        chk("idle e_out", 32'(e0), 0);
        chk("idle hold", 32'(out0), 64);

        step(0, 1, 49, 0);
        chk("t3 win change out", 32'(out0), 49);
        chk("t3 win change filled", 32'(f0), 1);
        step(0, 1, 90, 0);
        chk("t3 next out", 32'(out0), 90);

        step(1, 1, 500, 0);
        chk("t4 rst out", 32'(out0), 0);
        chk("t4 rst e_out", 32'(e0), 0);
        chk("t4 rst filled", 32'(f0), 0);
        step(0, 1, 90, 2);
        chk("t4 floor 90/4", 32'(out0), 22);
        chk("t4 round 90/4", 32'(out1), 23);

        for (int i = 0; i < 20; i++) begin
            step(0, 1, 1023, 4);
            if (i == 0) chk("t5 first", 32'(out0), 63);
            if (i == 1) chk("t5 second", 32'(out0), 127);
            if (i == 14) chk("t5 filled before 16th", 32'(f0), 0);
            if (i >= 15) chk("t5 saturated out", 32'(out0), 1023);
            if (i >= 15) chk("t5 filled", 32'(f0), 1);
        end

        step(1, 0, 0, 7);
        for (int i = 0; i < 16; i++) begin
            step(0, 1, 1023, 7);
            if (i == 0) chk("t5 clamp first", 32'(out0), 63);
            if (i == 15) chk("t5 clamp 16th", 32'(out0), 1023);
            if (i == 15) chk("t5 clamp filled", 32'(f0), 1);
        end

        step(0, 1, 10, 1);
        chk("t6 first", 32'(out0), 5);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1);
            chk("t6 gap hold", 32'(out0), 5);
            chk("t6 gap e_out", 32'(e0), 0);
        end
        step(0, 1, 30, 1);
        chk("t6 after gap", 32'(out0), 20);
        chk("t6 after gap round", 32'(out1), 20);

        checking = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
